// File: rtl/fir_transposed_param.sv
// Transposed-form FIR with valid-qualified samples, double-buffered coefficients,
// round-half-up output saturation and warm-up suppression after reset or commit.
module fir_transposed_param #(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned COEF_W          = 16,
    parameter int unsigned COEF_FRAC       = 14,
    parameter int unsigned NTAPS           = 57,
    parameter int unsigned ACC_W           = 40,
    parameter int unsigned OUT_W           = 16,
    parameter bit          SUPPRESS_WARMUP = 1'b1
) (
    input  logic                       clock_50,
    input  logic                       reset_n,
    input  logic signed [DATA_W-1:0]   din,
    input  logic                       din_valid,
    output logic signed [OUT_W-1:0]    dout,
    output logic                       dout_valid,
    input  logic                       coef_wr_en,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic                       coef_commit,
    output logic                       sat_flag,
    input  logic                       sat_clear,
    output logic                       busy_warmup
);

    localparam int unsigned AddrW = $clog2(NTAPS);
    localparam int unsigned ProdW = DATA_W + COEF_W;

    localparam logic signed [COEF_W-1:0] CoefOne = COEF_W'(1) << COEF_FRAC;
    localparam logic signed [ACC_W-1:0]  RndHalf = ACC_W'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0]  OutMax  =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  OutMin  =
        {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [0:0] {StRun, StWarm} state_e;

    logic signed [COEF_W-1:0] shad_q [NTAPS];
    logic signed [COEF_W-1:0] act_q  [NTAPS];
    logic signed [ProdW-1:0]  prod_q [NTAPS];
    logic signed [ACC_W-1:0]  acc_q  [1:NTAPS-1];

    logic signed [DATA_W-1:0] x1_q;
    logic                     v1_q, v2_q, v3_q;
    logic signed [OUT_W-1:0]  dout_q;
    logic                     sat_flag_q, sat_flag_d;
    state_e                   state_q, state_d;
    logic [AddrW-1:0]         wcnt_q, wcnt_d;

    logic                     addr_ok;
    logic signed [ACC_W-1:0]  sum, rnd;
    logic                     sat_hi, sat_lo, sat_set;
    logic signed [OUT_W-1:0]  y_sat;

    assign addr_ok = (32'(coef_addr) < NTAPS);

    // Output stage: last adder of the chain, then round-half-up and clamp.
    always_comb begin
        sum    = acc_q[1] + ACC_W'(prod_q[0]);
        rnd    = (sum + RndHalf) >>> COEF_FRAC;
        sat_hi = (rnd > OutMax);
        sat_lo = (rnd < OutMin);
        if (sat_hi) begin
            y_sat = OutMax[OUT_W-1:0];
        end else if (sat_lo) begin
            y_sat = OutMin[OUT_W-1:0];
        end else begin
            y_sat = rnd[OUT_W-1:0];
        end
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                shad_q[k] <= (k == 0) ? CoefOne : '0;
                act_q[k]  <= (k == 0) ? CoefOne : '0;
            end
        end else begin
            if (coef_commit) begin
                for (int unsigned k = 0; k < NTAPS; k++) begin
                    act_q[k] <= shad_q[k];
                end
            end
            // Same-cycle write lands in shadow only; active got the old copy above.
            if (coef_wr_en && addr_ok) begin
                shad_q[coef_addr] <= coef_data;
            end
        end
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            x1_q       <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            dout_q     <= '0;
            sat_flag_q <= 1'b0;
            for (int unsigned k = 0; k < NTAPS; k++) begin
                prod_q[k] <= '0;
            end
            for (int unsigned k = 1; k < NTAPS; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            v1_q       <= din_valid & ~coef_commit;
            v2_q       <= v1_q & ~coef_commit;
            v3_q       <= v2_q & ~coef_commit;
            sat_flag_q <= sat_flag_d;
            if (coef_commit) begin
                x1_q <= '0;
                for (int unsigned k = 0; k < NTAPS; k++) begin
                    prod_q[k] <= '0;
                end
                for (int unsigned k = 1; k < NTAPS; k++) begin
                    acc_q[k] <= '0;
                end
            end else begin
                if (din_valid) begin
                    x1_q <= din;
                end
                if (v1_q) begin
                    for (int unsigned k = 0; k < NTAPS; k++) begin
                        prod_q[k] <= ProdW'(x1_q) * ProdW'(act_q[k]);
                    end
                end
                // Chain advances only on valid samples so gaps do not shift history.
                if (v2_q) begin
                    for (int unsigned k = 1; k < NTAPS - 1; k++) begin
                        acc_q[k] <= acc_q[k+1] + ACC_W'(prod_q[k]);
                    end
                    acc_q[NTAPS-1] <= ACC_W'(prod_q[NTAPS-1]);
                    dout_q         <= y_sat;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (!SUPPRESS_WARMUP) begin
            state_d = StRun;
            wcnt_d  = '0;
        end else if (coef_commit) begin
            state_d = StWarm;
            wcnt_d  = '0;
        end else if (state_q == StWarm && v3_q) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == AddrW'(NTAPS - 2)) begin
                state_d = StRun;
            end
        end
    end

    // Flag only outputs that will be presented valid, i.e. loaded while the FSM is in RUN.
    assign sat_set = v2_q & ~coef_commit & (sat_hi | sat_lo) & (state_d == StRun);

    always_comb begin
        sat_flag_d = sat_flag_q;
        if (sat_set) begin
            sat_flag_d = 1'b1;
        end else if (sat_clear) begin
            sat_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SUPPRESS_WARMUP ? StWarm : StRun;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = v3_q & (state_q == StRun);
    assign sat_flag    = sat_flag_q;
    assign busy_warmup = (state_q == StWarm);

endmodule

// File: tb/tb_fir_transposed_param.sv
// Bench for fir_transposed_param: directed scenarios plus random traffic, all checked
// cycle by cycle against a plain-arithmetic convolution model.
module tb_fir_transposed_param;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 14;
    localparam int NTAPS     = 57;
    localparam int ACC_W     = 40;
    localparam int OUT_W     = 16;
    localparam bit SUPPRESS  = 1'b1;
    localparam int AW        = $clog2(NTAPS);

    logic                     clock_50 = 1'b0;
    logic                     reset_n;
    logic signed [DATA_W-1:0] din;
    logic                     din_valid;
    logic signed [OUT_W-1:0]  dout;
    logic                     dout_valid;
    logic                     coef_wr_en;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_commit;
    logic                     sat_flag;
    logic                     sat_clear;
    logic                     busy_warmup;

    fir_transposed_param #(
        .DATA_W         (DATA_W),
        .COEF_W         (COEF_W),
        .COEF_FRAC      (COEF_FRAC),
        .NTAPS          (NTAPS),
        .ACC_W          (ACC_W),
        .OUT_W          (OUT_W),
        .SUPPRESS_WARMUP(SUPPRESS)
    ) dut (
        .clock_50   (clock_50),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .coef_wr_en (coef_wr_en),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_commit(coef_commit),
        .sat_flag   (sat_flag),
        .sat_clear  (sat_clear),
        .busy_warmup(busy_warmup)
    );

    always #5 clock_50 = ~clock_50;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef struct {
        bit     v;
        bit     shown;
        bit     sat;
        longint y;
    } ent_t;

    longint act   [NTAPS];
    longint shad  [NTAPS];
    longint hist  [$];
    int     nacc;
    int     nout;
    ent_t   pipe  [3];
    bit     m_sat;
    longint got_q [$];

    function automatic void model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            act[k]  = (k == 0) ? (64'sd1 <<< COEF_FRAC) : 0;
            shad[k] = act[k];
        end
        hist.delete();
        nacc  = 0;
        nout  = 0;
        m_sat = 0;
        for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, shown: 0, sat: 0, y: 0};
    endfunction

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Model: sample-level convolution over accepted samples since the last reset/commit.
    initial begin
        model_reset();
        forever begin
            @(posedge clock_50 or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                ent_t   e;
                longint s;
                longint r;
                longint omax;
                longint omin;
                omax = (64'sd1 <<< (OUT_W - 1)) - 1;
                omin = -(64'sd1 <<< (OUT_W - 1));
                e = '{v: 0, shown: 0, sat: 0, y: 0};
                if (pipe[2].v) nout++;
                if (coef_commit) begin
                    for (int k = 0; k < NTAPS; k++) act[k] = shad[k];
                    hist.delete();
                    nacc = 0;
                    nout = 0;
                end
                if (din_valid && !coef_commit) begin
                    hist.push_front(longint'(din));
                    if (hist.size() > NTAPS) void'(hist.pop_back());
                    s = 0;
                    for (int k = 0; k < hist.size(); k++) s += act[k] * hist[k];
                    r = (s + (64'sd1 <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
                    e.v = 1;
                    if (r > omax) begin
                        e.y   = omax;
                        e.sat = 1;
                    end else if (r < omin) begin
                        e.y   = omin;
                        e.sat = 1;
                    end else begin
                        e.y = r;
                    end
                    e.shown = !SUPPRESS || (nacc >= NTAPS - 1);
                    nacc++;
                end
                if (coef_commit) begin
                    for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, shown: 0, sat: 0, y: 0};
                end else begin
                    pipe[2] = pipe[1];
                    pipe[1] = pipe[0];
                    pipe[0] = e;
                end
                if (pipe[2].v && pipe[2].shown && pipe[2].sat) m_sat = 1;
                else if (sat_clear) m_sat = 0;
                if (coef_wr_en && int'(coef_addr) < NTAPS) shad[coef_addr] = longint'(coef_data);
            end
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clock_50);
            if (reset_n) begin
                bit exp_v;
                exp_v = pipe[2].v && pipe[2].shown;
                chk("dout_valid", longint'(dout_valid), longint'(exp_v));
                chk("busy_warmup", longint'(busy_warmup), longint'(SUPPRESS && nout < NTAPS - 1));
                chk("sat_flag", longint'(sat_flag), longint'(m_sat));
                if (exp_v) begin
                    chk("dout", longint'(dout), pipe[2].y);
                    got_q.push_back(longint'(dout));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic send(input bit v, input int d);
        din_valid = v;
        din       = d[DATA_W-1:0];
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input int data);
        coef_wr_en = 1'b1;
        coef_addr  = addr[AW-1:0];
        coef_data  = data[COEF_W-1:0];
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    task automatic warm_zeros();
        for (int i = 0; i < NTAPS - 1; i++) send(1'b1, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_out(input string name, input longint want);
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no valid output, want %0d", name, want);
        end else begin
            chk(name, got_q.pop_front(), want);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        din         = '0;
        din_valid   = 1'b0;
        coef_wr_en  = 1'b0;
        coef_addr   = '0;
        coef_data   = '0;
        coef_commit = 1'b0;
        sat_clear   = 1'b0;
        idle(3);
        chk("reset_dout", longint'(dout), 0);
        chk("reset_dout_valid", longint'(dout_valid), 0);
        chk("reset_sat_flag", longint'(sat_flag), 0);
        chk("reset_busy", longint'(busy_warmup), 1);
        reset_n = 1'b1;
        tick();

        // 1: unity passthrough after warm-up
        got_q.delete();
        for (int i = 0; i < 60; i++) send(1'b1, 100 + i);
        idle(4);
        for (int i = 0; i < 4; i++) expect_out("t1_passthru", 156 + i);

        // 2: ramp coefficients, impulse response
        for (int k = 0; k < NTAPS; k++) wr_coef(k, k + 1);
        commit();
        got_q.delete();
        warm_zeros();
        send(1'b1, 16384);
        for (int i = 0; i < NTAPS; i++) send(1'b1, 0);
        idle(4);
        for (int k = 0; k < NTAPS; k++) expect_out("t2_impulse", k + 1);
        expect_out("t2_tail", 0);

        // 3: saturation both ways, sticky flag, clear
        wr_coef(0, 32767);
        for (int k = 1; k < NTAPS; k++) wr_coef(k, 0);
        commit();
        got_q.delete();
        warm_zeros();
        send(1'b1, 32767);
        idle(3);
        expect_out("t3_sat_hi", 32767);
        chk("t3_flag_set", longint'(sat_flag), 1);
        send(1'b1, -32768);
        idle(3);
        expect_out("t3_sat_lo", -32768);
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        chk("t3_flag_clear", longint'(sat_flag), 0);

        // 4: half-gain rounding
        wr_coef(0, 8192);
        commit();
        got_q.delete();
        warm_zeros();
        send(1'b1, 3);
        send(1'b1, -3);
        send(1'b1, 1);
        send(1'b1, -1);
        idle(4);
        expect_out("t4_p3", 2);
        expect_out("t4_m3", -1);
        expect_out("t4_p1", 1);
        expect_out("t4_m1", 0);

        // 5: gaps in the valid stream
        wr_coef(0, 16384);
        commit();
        warm_zeros();
        got_q.delete();
        send(1'b1, 11);
        send(1'b0, 12);
        send(1'b0, 13);
        send(1'b1, 14);
        send(1'b1, 15);
        send(1'b0, 16);
        send(1'b1, 17);
        idle(4);
        expect_out("t5_gap0", 11);
        expect_out("t5_gap1", 14);
        expect_out("t5_gap2", 15);
        expect_out("t5_gap3", 17);

        // 6: commit with colliding sample and shadow write
        got_q.delete();
        send(1'b1, 500);
        send(1'b1, 501);
        din_valid   = 1'b1;
        din         = 16'sd777;
        coef_commit = 1'b1;
        coef_wr_en  = 1'b1;
        coef_addr   = '0;
        coef_data   = '0;
        tick();
        din_valid   = 1'b0;
        coef_commit = 1'b0;
        coef_wr_en  = 1'b0;
        chk("t6_busy_restart", longint'(busy_warmup), 1);
        idle(4);
        chk("t6_inflight_dropped", longint'(got_q.size()), 0);
        warm_zeros();
        send(1'b1, 900);
        idle(3);
        expect_out("t6_active_unity", 900);
        commit();
        warm_zeros();
        send(1'b1, 1234);
        idle(3);
        expect_out("t6_shadow_write", 0);

        // Mid-stream reset with sat_flag set
        wr_coef(0, 32767);
        commit();
        warm_zeros();
        send(1'b1, 32767);
        idle(3);
        chk("t6_pre_reset_sat", longint'(sat_flag), 1);
        send(1'b1, 5);
        din_valid = 1'b1;
        din       = 16'sd6;
        reset_n   = 1'b0;
        #1;
        chk("t6_rst_dout", longint'(dout), 0);
        chk("t6_rst_valid", longint'(dout_valid), 0);
        chk("t6_rst_sat", longint'(sat_flag), 0);
        chk("t6_rst_busy", longint'(busy_warmup), 1);
        din_valid = 1'b0;
        idle(2);
        reset_n = 1'b1;
        tick();
        got_q.delete();
        warm_zeros();
        send(1'b1, 321);
        idle(3);
        expect_out("t6_unity_after_reset", 321);

        // Random traffic
        for (int k = 0; k < NTAPS; k++) wr_coef(k, int'($urandom_range(0, 4000)) - 2000);
        commit();
        for (int i = 0; i < 2000; i++) begin
            din_valid   = ($urandom_range(0, 99) < 70);
            din         = DATA_W'($urandom);
            coef_wr_en  = ($urandom_range(0, 99) < 5);
            coef_addr   = AW'($urandom_range(0, 63));
            coef_data   = COEF_W'(int'($urandom_range(0, 4000)) - 2000);
            coef_commit = ($urandom_range(0, 399) == 0);
            sat_clear   = ($urandom_range(0, 99) < 3);
            tick();
        end
        din_valid   = 1'b0;
        coef_wr_en  = 1'b0;
        coef_commit = 1'b0;
        sat_clear   = 1'b0;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_transposed_param.md
Name: fir_transposed_param

Overview:
Parametrised transposed-form FIR filter, the successor to the fixed 57-tap low-pass. It adds the following over the fixed design:
- generic tap count and widths
- a valid-qualified sample stream
- run-time reloadable coefficients (shadow bank plus atomic commit)
- round-half-up with output saturation
- warm-up suppression after reset or a coefficient change

It sits between the waveform source and the DAC/output formatter.

Parameters:
DATA_W, 16, signed input sample width
COEF_W, 16, signed coefficient width
COEF_FRAC, 14, coefficient fractional bits; also the output right-shift
NTAPS, 57, number of taps (min 2)
ACC_W, 40, accumulator width; must be >= DATA_W+COEF_W+clog2(NTAPS)
OUT_W, 16, signed output width
SUPPRESS_WARMUP, 1, 1 = hold dout_valid low for NTAPS-1 samples after reset or commit

Ports:
clock_50  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
din  in  DATA_W  signed input sample
din_valid  in  1  din qualifier
dout  out  OUT_W  signed filtered output
dout_valid  out  1  dout qualifier
coef_wr_en  in  1  write coef_data to shadow[coef_addr]
coef_addr  in  clog2(NTAPS)  shadow tap index
coef_data  in  COEF_W  signed coefficient value
coef_commit  in  1  single-cycle pulse: copy shadow bank to active bank
sat_flag  out  1  sticky: set when any output saturated
sat_clear  in  1  clears sat_flag
busy_warmup  out  1  high while warm-up is in progress

Behaviour:
- Function: y[n] = sum_{k=0..NTAPS-1} c[k]·x[n-k], with n indexing valid samples only. History before reset or commit counts as 0.
- Pipeline:
  - S1 registers din and din_valid.
  - S2 registers products p[k] = x·c[k] (full DATA_W+COEF_W width) when v1.
  - Transposed chain: acc[k] <= acc[k+1] + p[k] when v2 (acc[NTAPS-1] <= p[NTAPS-1]).
  - S3 registers the rounded/saturated (acc[1] + p[0]) when v2.
- Latency: dout_valid is din_valid delayed exactly 3 cycles, gaps preserved. The chain advances only on valid samples.
- All arithmetic is signed and sign-extended to ACC_W.
- Output rounding: r = (sum + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round-half-up).
  - r > 2^(OUT_W-1)-1 → dout = max; r < -2^(OUT_W-1) → dout = min.
  - A saturation on a valid output sets sat_flag.
  - sat_clear and a new saturation in the same cycle: set wins.
- Coefficients:
  - Two banks, shadow and active. The filter always uses active.
  - Writes with coef_addr >= NTAPS are ignored.
  - Reset value of both banks: c[0] = 2^COEF_FRAC, all others 0 (unity passthrough).
- Commit cycle:
  - active <= shadow.
  - Delay chain, product registers and S1–S3 valid bits are cleared; in-flight samples are dropped.
  - A din_valid sample presented in the commit cycle is discarded.
  - A coef_wr_en in the commit cycle updates shadow after the copy, so it is not included in active.
- Warm-up FSM:
  - States RUN and WARM. A counter wcnt (clog2(NTAPS) bits) counts S3-valid outputs.
  - Reset or commit → WARM, wcnt = 0.
  - In WARM, each S3-valid output increments wcnt with dout_valid forced low. When wcnt reaches NTAPS-1 → RUN.
  - RUN → WARM only on commit.
  - A commit while in WARM restarts the count.
  - busy_warmup = (state == WARM).
  - SUPPRESS_WARMUP = 0: the FSM is held in RUN.
- Reset values (asynchronous): dout = 0, dout_valid = 0, sat_flag = 0, busy_warmup = 1 (0 if SUPPRESS_WARMUP = 0). All pipeline registers and acc are 0. Coefficient banks are at their reset values.
- Reset asserted mid-stream: everything returns to reset values immediately; no output is produced from pre-reset samples.

Test Plan:
1. Reset, then 60 consecutive valid samples din = 100..159 → the first 56 outputs have dout_valid = 0 and busy_warmup = 1. The 57th onward have dout = din of the same sample (100+56 = 156, ...), dout_valid rising 3 cycles after that din.
2. Load c[k] = k+1 for k = 0..56, commit, feed 56 zeros, then impulse 16384 followed by zeros → dout sequence 1, 2, ..., 57, then 0.
3. c[0] = 32767 (others 0), commit, warm up with zeros, then din = 32767 → dout = 32767 and sat_flag = 1. Then din = -32768 → dout = -32768. Pulse sat_clear → sat_flag = 0.
4. c[0] = 8192 (0.5) → din = 3 gives 2; din = -3 gives -1; din = 1 gives 1; din = -1 gives 0.
5. Unity default after warm-up, din_valid pattern 1,0,0,1,1,0,1 → dout_valid shows the same pattern 3 cycles later; dout values match the valid dins in order.
6. Mid-stream: assert coef_commit together with din_valid and a shadow write to addr 0 → that din is dropped, the addr-0 write is absent from active, and warm-up restarts. Then drop reset_n low mid-stream → dout = 0, dout_valid = 0, coefficients revert to unity, sat_flag = 0.
